// File: rtl/nibble_sum_pkg.sv
// nibble_sum_pkg: shared types and width defaults for the nibble
// adder checker and the adder top it sits behind.
package nibble_sum_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/nibble_sum_ref.sv
// nibble_sum_ref: reference adder and comparator.
// Stage 1 registers the recomputed sum; stage 2 flags a mismatch.
module nibble_sum_ref
   import nibble_sum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_op_a,
   input  logic [DATA_W-1:0] i_op_b,
   input  logic [DATA_W-1:0] i_sum,
   input  logic [CNT_W-1:0]  i_idx,
   output logic              o_mis,
   output logic [CNT_W-1:0]  o_idx
);

   logic              r_s1_valid;
   logic [DATA_W-1:0] r_s1_ref;
   logic [DATA_W-1:0] r_s1_sum;
   logic [CNT_W-1:0]  r_s1_idx;

   // stage 1: capture recomputed sum (carry dropped by width)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_ref   <= '0;
         r_s1_sum   <= '0;
         r_s1_idx   <= '0;
      end else begin
         r_s1_valid <= i_valid;
         if (i_valid) begin
            r_s1_ref <= i_op_a + i_op_b;
            r_s1_sum <= i_sum;
            r_s1_idx <= i_idx;
         end
      end
   end

   // stage 2: compare; the owner folds the pulse into its counters
   always_comb begin
      o_mis = r_s1_valid && (r_s1_ref != r_s1_sum);
      o_idx = r_s1_idx;
   end

endmodule

// File: rtl/nibble_sum_checker.sv
// nibble_sum_checker: batch checker for operand/sum streams.
// Runs num_txn transactions, reports pass, error count, first error.
module nibble_sum_checker
   import nibble_sum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_txn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [DATA_W-1:0] sum_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic              first_err_valid
);

   state_t           r_state;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_err;
   logic [CNT_W-1:0] r_first_idx;
   logic             r_first_valid;

   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_mis;
   logic [CNT_W-1:0] w_mis_idx;

   assign w_accept  = in_valid & r_in_ready;
   assign w_cnt_inc = r_cnt + 1'b1;

   nibble_sum_ref #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_ref (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_accept),
      .i_op_a  (op_a),
      .i_op_b  (op_b),
      .i_sum   (sum_in),
      .i_idx   (r_cnt),
      .o_mis   (w_mis),
      .o_idx   (w_mis_idx)
   );

   // batch FSM with error accumulation and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_num         <= '0;
         r_cnt         <= '0;
         r_in_ready    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_err         <= '0;
         r_first_idx   <= '0;
         r_first_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_mis) begin
            if (r_err != {CNT_W{1'b1}}) begin
               r_err <= r_err + 1'b1;
            end
            if (!r_first_valid) begin
               r_first_idx   <= w_mis_idx;
               r_first_valid <= 1'b1;
            end
         end
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_num         <= num_txn;
                  r_cnt         <= '0;
                  r_err         <= '0;
                  r_first_idx   <= '0;
                  r_first_valid <= 1'b0;
                  r_pass        <= 1'b0;
                  if (num_txn == '0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state    <= S_RUN;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == r_num) begin
                     r_in_ready <= 1'b0;
                     r_state    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // in_ready is low, so nothing new enters stage 1 and
               // the last compare is folded into r_err on this edge
               r_busy  <= 1'b0;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_pass  <= (r_err == '0);
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready        = r_in_ready;
   assign busy            = r_busy;
   assign done            = r_done;
   assign pass            = r_pass;
   assign err_count       = r_err;
   assign first_err_idx   = r_first_idx;
   assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_nibble_sum_checker.sv
// tb_nibble_sum_checker: directed bench for nibble_sum_checker.
// Second instance uses CNT_W=2 for the narrow-counter batch.
module tb_nibble_sum_checker;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] num_txn;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [3:0] sum_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] first_err_idx;
   logic       first_err_valid;

   logic       s_start;
   logic [1:0] s_num;
   logic       s_valid;
   logic       s_ready;
   logic [3:0] s_a;
   logic [3:0] s_b;
   logic [3:0] s_sum;
   logic       s_busy;
   logic       s_done;
   logic       s_pass;
   logic [1:0] s_err;
   logic [1:0] s_fidx;
   logic       s_fev;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int rdy_cnt = 0;
   int done_cnt = 0;
   int last_acc = 0;

   logic [3:0] va [8];
   logic [3:0] vb [8];
   logic [3:0] vs [8];

   nibble_sum_checker #(.DATA_W(4), .CNT_W(8)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .num_txn         (num_txn),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .op_a            (op_a),
      .op_b            (op_b),
      .sum_in          (sum_in),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_err_idx   (first_err_idx),
      .first_err_valid (first_err_valid)
   );

   nibble_sum_checker #(.DATA_W(4), .CNT_W(2)) u_dut2 (
      .clk             (clk),
      .reset           (reset),
      .start           (s_start),
      .num_txn         (s_num),
      .in_valid        (s_valid),
      .in_ready        (s_ready),
      .op_a            (s_a),
      .op_b            (s_b),
      .sum_in          (s_sum),
      .busy            (s_busy),
      .done            (s_done),
      .pass            (s_pass),
      .err_count       (s_err),
      .first_err_idx   (s_fidx),
      .first_err_valid (s_fev)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
         acc_cnt  <= acc_cnt + 1;
         last_acc <= cyc + 1;
      end
      if (in_ready) rdy_cnt <= rdy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic setv(input int i, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] s);
      va[i] = a;
      vb[i] = b;
      vs[i] = s;
   endtask

   task automatic do_start(input logic [7:0] n);
      start   = 1'b1;
      num_txn = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int n, input bit toggle);
      int i = 0;
      int k = 0;
      while (i < n && k < 100) begin
         op_a     = va[i];
         op_b     = vb[i];
         sum_in   = vs[i];
         in_valid = toggle ? (k % 2 == 0) : 1'b1;
         if (in_valid && in_ready) i++;
         @(posedge clk); #1;
         k++;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL rst_in_ready: got %b want 0", in_ready);
      end
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL rst_busy_done: got %b%b want 00", busy, done);
      end
      tests++;
      if (pass !== 1'b0 || first_err_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_pass_fev: got %b%b want 00",
                  pass, first_err_valid);
      end
      tests++;
      if (err_count !== 8'd0 || first_err_idx !== 8'd0) begin
         fails++;
         $display("FAIL rst_counts: got %0d/%0d want 0/0",
                  err_count, first_err_idx);
      end
      #4 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int a0;
      int r0;
      int d0;
      bit ok;
      setv(0, 4'd3, 4'd5, 4'd8);
      setv(1, 4'd15, 4'd1, 4'd0);
      setv(2, 4'd7, 4'd7, 4'd14);
      setv(3, 4'd0, 4'd0, 4'd0);
      a0 = acc_cnt;
      r0 = rdy_cnt;
      d0 = done_cnt;
      do_start(8'd4);
      tests++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL basic_run: busy/ready %b%b want 11",
                  busy, in_ready);
      end
      feed(4, 1'b0);
      tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL basic_drain: ready/busy %b%b want 01",
                  in_ready, busy);
      end
      wait_done(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL basic_done: got no done want pulse");
      end
      tests++;
      if (pass !== 1'b1 || err_count !== 8'd0 ||
          first_err_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: pass %b err %0d fev %b want 1 0 0",
                  pass, err_count, first_err_valid);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle: done/busy %b%b want 00", done, busy);
      end
      tests++;
      if (acc_cnt - a0 != 4 || rdy_cnt - r0 != 4 ||
          done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL basic_counts: acc %0d rdy %0d done %0d want 4 4 1",
                  acc_cnt - a0, rdy_cnt - r0, done_cnt - d0);
      end
   endtask

   task automatic test_mismatch();
      do_start(8'd3);
      op_a = 4'd2; op_b = 4'd2; sum_in = 4'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      op_a = 4'd9; op_b = 4'd9; sum_in = 4'd3;
      @(posedge clk); #1;
      tests++;
      if (err_count !== 8'd0) begin
         fails++;
         $display("FAIL mis_early: err %0d want 0", err_count);
      end
      op_a = 4'd1; op_b = 4'd1; sum_in = 4'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (err_count !== 8'd1 || first_err_idx !== 8'd1 ||
          first_err_valid !== 1'b1) begin
         fails++;
         $display("FAIL mis_first: err %0d idx %0d fev %b want 1 1 1",
                  err_count, first_err_idx, first_err_valid);
      end
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL mis_ready: got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (err_count !== 8'd2 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL mis_final: err %0d busy %b done %b want 2 0 0",
                  err_count, busy, done);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b1 || pass !== 1'b0 || err_count !== 8'd2 ||
          first_err_idx !== 8'd1 || first_err_valid !== 1'b1) begin
         fails++;
         $display("FAIL mis_done: done %b pass %b err %0d idx %0d fev %b want 1 0 2 1 1",
                  done, pass, err_count, first_err_idx, first_err_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      int r0;
      r0 = rdy_cnt;
      do_start(8'd0);
      tests++;
      if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL zero_first: done/ready/busy %b%b%b want 000",
                  done, in_ready, busy);
      end
      tests++;
      if (err_count !== 8'd0 || first_err_valid !== 1'b0) begin
         fails++;
         $display("FAIL zero_clear: err %0d fev %b want 0 0",
                  err_count, first_err_valid);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         fails++;
         $display("FAIL zero_done: done/pass %b%b want 11", done, pass);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || rdy_cnt - r0 != 0) begin
         fails++;
         $display("FAIL zero_after: done %b rdy %0d want 0 0",
                  done, rdy_cnt - r0);
      end
   endtask

   task automatic test_toggle();
      int a0;
      bit ok;
      setv(0, 4'd1, 4'd2, 4'd3);
      setv(1, 4'd4, 4'd5, 4'd9);
      setv(2, 4'd8, 4'd8, 4'd0);
      setv(3, 4'd15, 4'd15, 4'd14);
      setv(4, 4'd6, 4'd3, 4'd9);
      a0 = acc_cnt;
      do_start(8'd5);
      start   = 1'b1;
      num_txn = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL tog_restart: busy/ready %b%b want 11",
                  busy, in_ready);
      end
      feed(5, 1'b1);
      wait_done(ok);
      tests++;
      if (!ok || cyc - last_acc != 2) begin
         fails++;
         $display("FAIL tog_latency: done %b gap %0d want 1 2",
                  ok, cyc - last_acc);
      end
      tests++;
      if (acc_cnt - a0 != 5) begin
         fails++;
         $display("FAIL tog_accepts: got %0d want 5", acc_cnt - a0);
      end
      tests++;
      if (pass !== 1'b1 || err_count !== 8'd0) begin
         fails++;
         $display("FAIL tog_result: pass %b err %0d want 1 0",
                  pass, err_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_narrow();
      int k;
      s_start = 1'b1;
      s_num   = 2'd3;
      @(posedge clk); #1;
      s_start = 1'b0;
      tests++;
      if (s_busy !== 1'b1 || s_ready !== 1'b1) begin
         fails++;
         $display("FAIL nar_run: busy/ready %b%b want 11", s_busy, s_ready);
      end
      for (int i = 0; i < 3; i++) begin
         s_a   = 4'(i + 1);
         s_b   = 4'(i + 1);
         s_sum = 4'd0;
         s_valid = 1'b1;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      k = 0;
      while (!s_done && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      tests++;
      if (s_done !== 1'b1 || s_err !== 2'd3 || s_fidx !== 2'd0 ||
          s_fev !== 1'b1 || s_pass !== 1'b0) begin
         fails++;
         $display("FAIL nar_sat: done %b err %0d idx %0d fev %b pass %b want 1 3 0 1 0",
                  s_done, s_err, s_fidx, s_fev, s_pass);
      end
      @(posedge clk); #1;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      tests++;
      if (s_err !== 2'd0 || s_fev !== 1'b0) begin
         fails++;
         $display("FAIL nar_clear: err %0d fev %b want 0 0", s_err, s_fev);
      end
      s_a = 4'd8; s_b = 4'd8; s_sum = 4'd1; s_valid = 1'b1;
      @(posedge clk); #1;
      s_a = 4'd1; s_b = 4'd2; s_sum = 4'd3;
      @(posedge clk); #1;
      s_a = 4'd4; s_b = 4'd4; s_sum = 4'd8;
      @(posedge clk); #1;
      s_valid = 1'b0;
      k = 0;
      while (!s_done && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      tests++;
      if (s_done !== 1'b1 || s_err !== 2'd1 || s_fidx !== 2'd0 ||
          s_fev !== 1'b1 || s_pass !== 1'b0) begin
         fails++;
         $display("FAIL nar_rerun: done %b err %0d idx %0d fev %b pass %b want 1 1 0 1 0",
                  s_done, s_err, s_fidx, s_fev, s_pass);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int d0;
      bit ok;
      d0 = done_cnt;
      do_start(8'd4);
      op_a = 4'd1; op_b = 4'd1; sum_in = 4'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      op_a = 4'd2; op_b = 4'd3; sum_in = 4'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (err_count !== 8'd1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: err %0d busy %b want 1 1", err_count, busy);
      end
      #3 reset = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          pass !== 1'b0 || first_err_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_flags: rdy %b busy %b done %b pass %b fev %b want 00000",
                  in_ready, busy, done, pass, first_err_valid);
      end
      tests++;
      if (err_count !== 8'd0 || first_err_idx !== 8'd0) begin
         fails++;
         $display("FAIL mid_counts: err %0d idx %0d want 0 0",
                  err_count, first_err_idx);
      end
      #10 reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (done_cnt - d0 != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_nodone: done %0d busy %b want 0 0",
                  done_cnt - d0, busy);
      end
      setv(0, 4'd5, 4'd5, 4'd10);
      setv(1, 4'd9, 4'd7, 4'd0);
      do_start(8'd2);
      feed(2, 1'b0);
      wait_done(ok);
      tests++;
      if (!ok || pass !== 1'b1 || err_count !== 8'd0 ||
          first_err_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_clean: done %b pass %b err %0d fev %b want 1 1 0 0",
                  ok, pass, err_count, first_err_valid);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      num_txn  = 8'd0;
      in_valid = 1'b0;
      op_a     = 4'd0;
      op_b     = 4'd0;
      sum_in   = 4'd0;
      s_start  = 1'b0;
      s_num    = 2'd0;
      s_valid  = 1'b0;
      s_a      = 4'd0;
      s_b      = 4'd0;
      s_sum    = 4'd0;
      test_reset();
      test_basic();
      test_mismatch();
      test_zero();
      test_toggle();
      test_narrow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
